vga_line_prefetch: RTL and testbench

Line-prefetch scheduler between frame-buffer memory and `vga_ctrl`. Fetches each display line from external memory in fixed-length read bursts into a two-bank (ping-pong) line buffer one line ahead of the raster, then serves `pix_data` to `vga_ctrl` from the bank being displayed. Sequences all memory read traffic for display, and flags underruns when a line is not fully fetched in time.

---
 rtl/vga_line_prefetch.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_line_prefetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_prefetch
// Brief    : Fetches display lines one ahead of the raster into a ping-pong
//            line buffer and serves pixels to vga_ctrl, flagging underruns.
//            Optional VGA_PREFETCH_STATS_EN adds a saturating underrun_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_prefetch #(
  parameter int          H_VALID   = 640,
  parameter int          V_VALID   = 480,
  parameter int          BURST_LEN = 16,
  parameter logic [18:0] FB_BASE   = 19'd0
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_data_req,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        rd_req,
  output logic [18:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
`ifdef VGA_PREFETCH_STATS_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic        underrun
);

  localparam int          BW           = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [9:0]  C_LAST_WPTR  = 10'(H_VALID - 1);
  localparam logic [9:0]  C_LAST_LINE  = 10'(V_VALID - 1);
  localparam logic [9:0]  C_H_VALID    = 10'(H_VALID);
  localparam logic [18:0] C_BURST_STEP = 19'(BURST_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Line start address; the 640-wide case uses shift-add instead of a multiplier.
  function automatic logic [18:0] line_base(input logic [9:0] l);
    logic [18:0] lw;
    lw = {9'd0, l};
    if (H_VALID == 640) return FB_BASE + (lw << 9) + (lw << 7);
    else                return FB_BASE + 19'(int'(l) * H_VALID);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [9:0]    line_q, line_d;
  logic [9:0]    wptr_q, wptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [18:0]   rd_addr_q, rd_addr_d;
  logic          abort_q, abort_d;
  logic          pend_vld_q, pend_vld_d;
  logic [9:0]    pend_line_q, pend_line_d;
  logic [1:0]    bank_valid_q, bank_valid_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic          underrun_q, underrun_d;
`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0]   underrun_cnt_q, underrun_cnt_d;
`endif

  logic [15:0]   bank_mem [2][H_VALID];

  logic          w_line_trig;
  logic          w_trig;
  logic [9:0]    w_trig_line;
  logic [9:0]    w_start_line;
  logic          w_abort;
  logic          w_last_beat;
  logic          w_wr_en;
  logic          w_rd_bank;

  assign w_line_trig  = pix_data_req && (pix_x == 10'd0) && (pix_y < C_LAST_LINE);
  assign w_trig       = frame_start | w_line_trig;
  assign w_trig_line  = frame_start ? 10'd0 : (pix_y + 10'd1);
  assign w_start_line = w_trig ? w_trig_line : pend_line_q;
  assign w_abort      = abort_q | frame_start;
  assign w_last_beat  = (beat_q == C_LAST_BEAT);
  assign w_rd_bank    = pix_y[0];

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= 10'd0;
      wptr_q       <= 10'd0;
      beat_q       <= '0;
      rd_addr_q    <= 19'd0;
      abort_q      <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_line_q  <= 10'd0;
      bank_valid_q <= 2'b00;
      pix_data_q   <= 16'h0000;
      underrun_q   <= 1'b0;
`ifdef VGA_PREFETCH_STATS_EN
      underrun_cnt_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      wptr_q       <= wptr_d;
      beat_q       <= beat_d;
      rd_addr_q    <= rd_addr_d;
      abort_q      <= abort_d;
      pend_vld_q   <= pend_vld_d;
      pend_line_q  <= pend_line_d;
      bank_valid_q <= bank_valid_d;
      pix_data_q   <= pix_data_d;
      underrun_q   <= underrun_d;
`ifdef VGA_PREFETCH_STATS_EN
      underrun_cnt_q <= underrun_cnt_d;
`endif
    end
  end

  always_ff @(posedge vga_clk) begin
    if (w_wr_en) bank_mem[line_q[0]][wptr_q] <= rd_data;
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    wptr_d       = wptr_q;
    beat_d       = beat_q;
    rd_addr_d    = rd_addr_q;
    abort_d      = abort_q;
    pend_vld_d   = pend_vld_q;
    pend_line_d  = pend_line_q;
    bank_valid_d = bank_valid_q;
    w_wr_en      = 1'b0;

    if (w_line_trig) bank_valid_d[w_trig_line[0]] = 1'b0;
    if (frame_start) bank_valid_d = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (w_trig || pend_vld_q) begin
          state_d    = S_REQ;
          line_d     = w_start_line;
          wptr_d     = 10'd0;
          beat_d     = '0;
          rd_addr_d  = line_base(w_start_line);
          pend_vld_d = 1'b0;
          abort_d    = 1'b0;
        end
      end
      S_REQ: begin
        if (w_trig) begin
          pend_vld_d  = 1'b1;
          pend_line_d = w_trig_line;
        end
        if (frame_start) abort_d = 1'b1;
        if (rd_ack) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (w_trig) begin
          pend_vld_d  = 1'b1;
          pend_line_d = w_trig_line;
        end
        if (frame_start) abort_d = 1'b1;
        if (rd_valid) begin
          beat_d = beat_q + BW'(1);
          // An aborted burst is drained from the memory but never lands in a bank.
          if (!w_abort) begin
            w_wr_en = 1'b1;
            wptr_d  = wptr_q + 10'd1;
          end
          if (w_last_beat) begin
            if (w_abort) begin
              state_d = S_IDLE;
              abort_d = 1'b0;
            end else if (wptr_q == C_LAST_WPTR) begin
              bank_valid_d[line_q[0]] = 1'b1;
              state_d = S_IDLE;
            end else begin
              rd_addr_d = rd_addr_q + C_BURST_STEP;
              state_d   = S_REQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_data_d = 16'h0000;
    underrun_d = underrun_q;
`ifdef VGA_PREFETCH_STATS_EN
    underrun_cnt_d = underrun_cnt_q;
`endif
    if (pix_data_req) begin
      if (!bank_valid_q[w_rd_bank]) begin
        underrun_d = 1'b1;
`ifdef VGA_PREFETCH_STATS_EN
        if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
`endif
      end else if (pix_x < C_H_VALID) begin
        pix_data_d = bank_mem[w_rd_bank][pix_x];
      end
    end
    if (frame_start) begin
      underrun_d = 1'b0;
`ifdef VGA_PREFETCH_STATS_EN
      underrun_cnt_d = 16'd0;
`endif
    end
  end

  always_comb begin
    rd_req   = (state_q == S_REQ);
    rd_addr  = rd_addr_q;
    pix_data = pix_data_q;
    underrun = underrun_q;
`ifdef VGA_PREFETCH_STATS_EN
    underrun_cnt = underrun_cnt_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_line_prefetch
// Brief    : Scoreboard bench with an addr-as-data memory model and a
//            bank-content reference model for vga_line_prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_line_prefetch;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BL = 16;
  localparam int NB = H / BL;

  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_data_req = 1'b0;
  logic [9:0]  pix_x = 10'd0;
  logic [9:0]  pix_y = 10'd0;
  logic [15:0] pix_data;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        rd_valid = 1'b0;
  logic        underrun;
`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 vga_clk = ~vga_clk;

  vga_line_prefetch dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .pix_data_req (pix_data_req),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
`ifdef VGA_PREFETCH_STATS_EN
    .underrun_cnt (underrun_cnt),
`endif
    .underrun     (underrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: configurable ack latency, addr-as-data beats starting the cycle after ack.
  int          ack_lat = 0;
  bit          gaps = 1'b0;
  int          beats_left = 0;
  logic [18:0] cur_addr = 19'd0;
  int          lat_cnt = 0;
  int          ack_count = 0;
  bit          skipped = 1'b0;
  int          inject = 0;

  always @(negedge vga_clk) begin
    rd_ack   = 1'b0;
    rd_valid = 1'b0;
    if (rst) begin
      beats_left = 0;
      lat_cnt    = 0;
    end else if (inject > 0) begin
      rd_valid = 1'b1;
      rd_data  = 16'hDEAD;
      inject--;
    end else if (beats_left > 0) begin
      if (gaps && !skipped && $urandom_range(3) == 0) skipped = 1'b1;
      else begin
        skipped  = 1'b0;
        rd_valid = 1'b1;
        rd_data  = cur_addr[15:0];
        cur_addr = cur_addr + 19'd1;
        beats_left--;
      end
    end else if (rd_req) begin
      if (lat_cnt >= ack_lat) begin
        rd_ack     = 1'b1;
        lat_cnt    = 0;
        beats_left = BL;
        cur_addr   = rd_addr;
        ack_count++;
      end else lat_cnt++;
    end
  end

  // Scoreboards
  logic [18:0] exp_addr_q[$];
  logic [15:0] exp_pix_q[$];
  bit          req_seen = 1'b0;

  always @(posedge vga_clk) req_seen <= pix_data_req;

  always @(negedge vga_clk) begin
    #1;
    if (rd_req && rd_ack) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL burst_addr: unexpected burst at 0x%0h, none required", rd_addr);
      end else check("burst_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
    end
  end

  always @(negedge vga_clk) begin
    if (req_seen) begin
      if (exp_pix_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pix_data: output 0x%0h with no request queued", pix_data);
      end else check("pix_data", 32'(pix_data), 32'(exp_pix_q.pop_front()));
    end else check("pix_idle", 32'(pix_data), 32'h0);
  end

  // Reference model: which line each bank holds completely (-1 = none).
  int bank_line[2] = '{-1, -1};
  bit und_exp = 1'b0;
  int cnt_exp = 0;
  int push_limit = NB;

  task automatic push_line(input int l, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(19'(l * H + i * BL));
  endtask

  task automatic drive(input bit req, input int x, input int y);
    int b;
    @(posedge vga_clk);
    #1;
    pix_data_req = req;
    pix_x = 10'(x);
    pix_y = 10'(y);
    if (req) begin
      b = y & 1;
      exp_pix_q.push_back(bank_line[b] >= 0 ? 16'(bank_line[b] * H + x) : 16'h0);
      if (bank_line[b] < 0) begin
        und_exp = 1'b1;
        if (cnt_exp < 65535) cnt_exp++;
      end
      if (x == 0 && y < V - 1) begin
        bank_line[(y + 1) & 1] = -1;
        push_line(y + 1, push_limit);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  task automatic pulse_fs();
    @(posedge vga_clk);
    #1;
    pix_data_req = 1'b0;
    frame_start  = 1'b1;
    bank_line    = '{-1, -1};
    und_exp      = 1'b0;
    cnt_exp      = 0;
    push_line(0, NB);
    @(posedge vga_clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic check_status(input string tag);
    @(negedge vga_clk);
    check({tag, "_underrun"}, 32'(underrun), 32'(und_exp));
`ifdef VGA_PREFETCH_STATS_EN
    check({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'(cnt_exp));
`endif
  endtask

  initial begin
    int base;
    repeat (4) @(posedge vga_clk);
    #1 rst = 1'b0;

    @(negedge vga_clk);
    check("rst_pix_data", 32'(pix_data), 32'h0);
    check("rst_rd_req",   32'(rd_req),   32'h0);
    check("rst_rd_addr",  32'(rd_addr),  32'h0);
    check_status("rst");

    // Line 0 with an immediate-ack memory
    ack_lat = 0;
    gaps    = 1'b0;
    pulse_fs();
    idle(800);
    bank_line[0] = 0;
    check("line0_bursts_left", 32'(exp_addr_q.size()), 32'd0);
    check("line0_burst_count", 32'(ack_count), 32'(NB));
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom_range(639, 1), 0);
    idle(3);
    check_status("line0");

    // Raster of 8 lines with random latency and beat gaps
    gaps = 1'b1;
    for (int y = 0; y < 8; y++) begin
      ack_lat = $urandom_range(2, 0);
      for (int x = 0; x < H; x++) drive((x == 0) || ($urandom_range(7) != 0), x, y);
      idle(860);
      bank_line[(y + 1) & 1] = y + 1;
    end
    check("raster_bursts_left", 32'(exp_addr_q.size()), 32'd0);
    check_status("raster");

    // Random reads hitting whichever line each bank holds
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, $urandom_range(639, 1), $urandom_range(V - 2, 0));
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(2);
    check_status("random");

    // Last line does not trigger a fetch
    base = ack_count;
    drive(1'b1, 0, V - 1);
    idle(200);
    check("lastline_no_fetch", 32'(ack_count), 32'(base));

    // Slow memory: line 0 not ready, reads return 0 and underrun sticks
    ack_lat = 40;
    gaps    = 1'b0;
    pulse_fs();
    idle(50);
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(639, 1), $urandom_range(1, 0));
    idle(2);
    check_status("slow");
    idle(3000);
    bank_line[0] = 0;
    check("slow_bursts_left", 32'(exp_addr_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom_range(639, 1), 0);
    idle(2);
    check_status("slow_sticky");
    ack_lat = 0;
    pulse_fs();
    check_status("fs_clear");
    idle(900);
    bank_line[0] = 0;

    // frame_start during the 3rd burst of line 200
    push_limit = 3;
    base = ack_count;
    drive(1'b1, 0, 199);
    push_limit = NB;
    for (int i = 0; i < 300 && ack_count < base + 3; i++) drive(1'b0, 0, 0);
    check("abort_third_burst_seen", 32'(ack_count >= base + 3), 32'd1);
    idle(5);
    pulse_fs();
    idle(900);
    bank_line[0] = 0;
    check("abort_bursts_left", 32'(exp_addr_q.size()), 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom_range(639, 1), 0);
    idle(2);
    check_status("abort");

    // Reset while rd_req is waiting for an ack, then stray beats
    ack_lat = 40;
    drive(1'b1, 0, 10);
    idle(10);
    check("rd_req_waiting", 32'(rd_req), 32'd1);
    @(posedge vga_clk);
    #1 rst = 1'b1;
    @(posedge vga_clk);
    #1 rst = 1'b0;
    exp_addr_q.delete();
    bank_line = '{-1, -1};
    und_exp   = 1'b0;
    cnt_exp   = 0;
    @(negedge vga_clk);
    check("mid_rst_rd_req",   32'(rd_req),   32'h0);
    check("mid_rst_rd_addr",  32'(rd_addr),  32'h0);
    check("mid_rst_pix_data", 32'(pix_data), 32'h0);
    check_status("mid_rst");
    inject = 5;
    idle(10);
    check("stray_no_req", 32'(rd_req), 32'h0);
    drive(1'b1, 5, 0);
    idle(3);
    check_status("stray");

    check("final_addr_queue", 32'(exp_addr_q.size()), 32'd0);
    check("final_pix_queue",  32'(exp_pix_q.size()),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
